// File: rtl/exp_scale_arb.sv
// exp_scale_arb: round-robin arbiter sharing one registered exponent-scale LUT
// among NUM_REQ exp-computation lanes. Grants at most one lookup per cycle,
// carries the requesting lane id alongside the LUT latency in a tag pipeline,
// and returns each scale word to its lane as a registered one-hot response.
module exp_scale_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 4,
    parameter int SCALE_W = 20,
    parameter int LUT_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [IDX_W-1:0]         lut_idx,
    input  logic [SCALE_W-1:0]       lut_scale,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [SCALE_W-1:0]       rsp_scale,
    output logic [1:0]               inflight
);

    // Lane-id width and the wider width used while wrapping the search index.
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = PTR_W + 1;

    // One-hot decode of a lane id into a per-lane vector.
    function automatic logic [NUM_REQ-1:0] lane_onehot(input logic [PTR_W-1:0] id);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            oh[i] = (id == PTR_W'(i));
        end
        return oh;
    endfunction

    // Arbitration state and results
    logic [PTR_W-1:0]   rr_ptr_r;
    logic               grant_s;
    logic [PTR_W-1:0]   gnt_id_s;
    logic [IDX_W-1:0]   gnt_idx_s;

    // LUT index hold, tag pipeline, response and occupancy state
    logic [IDX_W-1:0]   lut_idx_hold_r;
    logic               tag_v_r  [LUT_LAT];
    logic [PTR_W-1:0]   tag_id_r [LUT_LAT];
    logic [NUM_REQ-1:0] rsp_valid_r;
    logic [SCALE_W-1:0] rsp_scale_r;
    logic [2:0]         cnt_r;
    logic [2:0]         cnt_next_s;
    logic [1:0]         inflight_r;

    // Round-robin search: first requesting lane starting at rr_ptr, wrapping.
    always_comb begin
        logic [SUM_W-1:0] lane_sum_v;
        logic [PTR_W-1:0] lane_v;
        logic             sel_v;
        grant_s    = 1'b0;
        gnt_id_s   = '0;
        lane_sum_v = '0;
        lane_v     = '0;
        sel_v      = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            lane_sum_v = {1'b0, rr_ptr_r} + SUM_W'(k);
            lane_v     = (lane_sum_v >= SUM_W'(NUM_REQ)) ?
                         PTR_W'(lane_sum_v - SUM_W'(NUM_REQ)) : PTR_W'(lane_sum_v);
            sel_v      = ~grant_s & req_valid[lane_v];
            gnt_id_s   = sel_v ? lane_v : gnt_id_s;
            grant_s    = grant_s | sel_v;
        end
    end

    // Select the granted lane's index with a constant-indexed AND-OR mux.
    always_comb begin
        gnt_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_idx_s = gnt_idx_s |
                        ((grant_s && (gnt_id_s == PTR_W'(i))) ?
                         req_idx[i*IDX_W +: IDX_W] : {IDX_W{1'b0}});
        end
    end

    // One-hot ready to the granted lane; LUT sees the new index or the held one.
    always_comb begin
        req_ready = grant_s ? lane_onehot(gnt_id_s) : {NUM_REQ{1'b0}};
        lut_idx   = grant_s ? gnt_idx_s : lut_idx_hold_r;
    end

    // Advance the round-robin pointer past the lane just granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if (grant_s) begin
            rr_ptr_r <= (gnt_id_s == PTR_W'(NUM_REQ - 1)) ? PTR_W'(0) : (gnt_id_s + PTR_W'(1));
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Remember the last granted index so the LUT input is quiet on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_idx_hold_r <= '0;
        end else if (grant_s) begin
            lut_idx_hold_r <= gnt_idx_s;
        end else begin
            lut_idx_hold_r <= lut_idx_hold_r;
        end
    end

    // Tag pipeline: lane id travels alongside the lookup for LUT_LAT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LUT_LAT; k++) begin
                tag_v_r[k]  <= 1'b0;
                tag_id_r[k] <= '0;
            end
        end else begin
            tag_v_r[0]  <= grant_s;
            tag_id_r[0] <= gnt_id_s;
            for (int k = 1; k < LUT_LAT; k++) begin
                tag_v_r[k]  <= tag_v_r[k-1];
                tag_id_r[k] <= tag_id_r[k-1];
            end
        end
    end

    // Capture the LUT result for the lane at the end of the tag pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= '0;
            rsp_scale_r <= '0;
        end else if (tag_v_r[LUT_LAT-1]) begin
            rsp_valid_r <= lane_onehot(tag_id_r[LUT_LAT-1]);
            rsp_scale_r <= lut_scale;
        end else begin
            rsp_valid_r <= '0;
            rsp_scale_r <= rsp_scale_r;
        end
    end

    // Occupancy: one more per grant, one fewer per delivered response.
    always_comb begin
        cnt_next_s = cnt_r + (grant_s ? 3'd1 : 3'd0) - ((|rsp_valid_r) ? 3'd1 : 3'd0);
    end

    // Keep the full count internally and a saturated copy for the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= 3'd0;
            inflight_r <= 2'd0;
        end else begin
            cnt_r      <= cnt_next_s;
            inflight_r <= (cnt_next_s > 3'd3) ? 2'd3 : cnt_next_s[1:0];
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_scale = rsp_scale_r;
    assign inflight  = inflight_r;

    // Responses and grants must never address more than one lane at a time.
    a_rsp_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid_r));
    a_rdy_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

endmodule

// File: tb/tb_exp_scale_arb.sv
// Bench for exp_scale_arb: table of per-cycle stimulus with expected grant and
// LUT index, a registered LUT model, and a response scoreboard queue.
module tb_exp_scale_arb;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 4;
    localparam int SCALE_W = 20;
    localparam int LUT_LAT = 1;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*IDX_W-1:0] req_idx;
    logic [NUM_REQ-1:0]       req_ready;
    logic [IDX_W-1:0]         lut_idx;
    logic [SCALE_W-1:0]       lut_scale;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [SCALE_W-1:0]       rsp_scale;
    logic [1:0]               inflight;

    exp_scale_arb #(
        .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .SCALE_W(SCALE_W), .LUT_LAT(LUT_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_idx(req_idx),
        .req_ready(req_ready), .lut_idx(lut_idx), .lut_scale(lut_scale),
        .rsp_valid(rsp_valid), .rsp_scale(rsp_scale), .inflight(inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference exponent-scale contents.
    function automatic logic [SCALE_W-1:0] scale_of(input logic [IDX_W-1:0] idx);
        case (idx)
            4'h0:    return 20'h01000;
            4'h1:    return 20'h02B80;
            4'h2:    return 20'h07640;
            4'h8:    return 20'h00160;
            default: return {4'hA, idx, 12'h3C5};
        endcase
    endfunction

    // Registered LUT with LUT_LAT cycles of read latency.
    logic [SCALE_W-1:0] lut_pipe [LUT_LAT];
    always @(posedge clk) begin
        lut_pipe[0] <= scale_of(lut_idx);
        for (int k = 1; k < LUT_LAT; k++) lut_pipe[k] <= lut_pipe[k-1];
    end
    assign lut_scale = lut_pipe[LUT_LAT-1];

    typedef struct {
        logic               rst_n;
        logic [NUM_REQ-1:0] valid;
        logic [15:0]        idx;
        logic [NUM_REQ-1:0] exp_ready;
        logic [IDX_W-1:0]   exp_lut;
    } vec_t;

    typedef struct {
        int                 due;
        logic [NUM_REQ-1:0] lanes;
        logic [SCALE_W-1:0] scale;
    } exp_rsp_t;

    exp_rsp_t sb[$];
    vec_t     tbl[25];
    int       cyc;
    int       n_tests;
    int       n_fail;

    function automatic logic [15:0] pk(input logic [3:0] a3, input logic [3:0] a2,
                                       input logic [3:0] a1, input logic [3:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [15:0] ix,
                                input logic [3:0] er, input logic [3:0] el);
        vec_t t;
        t.rst_n = r; t.valid = v; t.idx = ix; t.exp_ready = er; t.exp_lut = el;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, check combinational and registered outputs.
    task automatic step(input vec_t v);
        exp_rsp_t e;
        int       lane;
        logic [1:0] exp_inf;
        rst_n     = v.rst_n;
        req_valid = v.valid;
        req_idx   = v.idx;
        if (!v.rst_n) sb.delete();
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(v.exp_ready));
        chk("lut_idx", 32'(lut_idx), 32'(v.exp_lut));
        exp_inf = (sb.size() > 3) ? 2'd3 : 2'(sb.size());
        chk("inflight", 32'(inflight), 32'(exp_inf));
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(e.lanes));
            chk("rsp_scale", 32'(rsp_scale), 32'(e.scale));
        end else begin
            chk("rsp_idle", 32'(rsp_valid), 32'd0);
        end
        if (v.exp_ready != 4'b0000) begin
            lane = 0;
            for (int i = 0; i < NUM_REQ; i++) if (v.exp_ready[i]) lane = i;
            e.due   = cyc + LUT_LAT + 1;
            e.lanes = v.exp_ready;
            e.scale = scale_of(v.idx[lane*IDX_W +: IDX_W]);
            sb.push_back(e);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0; req_valid = '0; req_idx = '0;

        // Reset, lane 0 alone, lane 1 alone x4, rr_ptr corner, continuous load.
        tbl[0]  = mk(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'h0);
        tbl[1]  = mk(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'h0);
        tbl[2]  = mk(1'b1, 4'b0000, 16'h0000, 4'b0000, 4'h0);
        tbl[3]  = mk(1'b1, 4'b0001, pk(4'h0, 4'h0, 4'h0, 4'h1), 4'b0001, 4'h1);
        tbl[4]  = mk(1'b1, 4'b0000, 16'h0000, 4'b0000, 4'h1);
        tbl[5]  = mk(1'b1, 4'b0000, 16'h0000, 4'b0000, 4'h1);
        for (int i = 6; i < 10; i++)
            tbl[i] = mk(1'b1, 4'b0010, 16'h0000, 4'b0010, 4'h0);
        tbl[10] = mk(1'b1, 4'b1001, pk(4'h7, 4'h0, 4'h0, 4'h5), 4'b1000, 4'h7);
        tbl[11] = mk(1'b1, 4'b0001, pk(4'h0, 4'h0, 4'h0, 4'h5), 4'b0001, 4'h5);
        tbl[12] = mk(1'b1, 4'b0011, pk(4'h0, 4'h0, 4'h3, 4'h6), 4'b0010, 4'h3);
        tbl[13] = mk(1'b1, 4'b1000, pk(4'h9, 4'h0, 4'h0, 4'h0), 4'b1000, 4'h9);
        for (int i = 14; i < 22; i += 4) begin
            tbl[i]   = mk(1'b1, 4'b1111, pk(4'h8, 4'h2, 4'h1, 4'h0), 4'b0001, 4'h0);
            tbl[i+1] = mk(1'b1, 4'b1111, pk(4'h8, 4'h2, 4'h1, 4'h0), 4'b0010, 4'h1);
            tbl[i+2] = mk(1'b1, 4'b1111, pk(4'h8, 4'h2, 4'h1, 4'h0), 4'b0100, 4'h2);
            tbl[i+3] = mk(1'b1, 4'b1111, pk(4'h8, 4'h2, 4'h1, 4'h0), 4'b1000, 4'h8);
        end
        for (int i = 22; i < 25; i++)
            tbl[i] = mk(1'b1, 4'b0000, 16'h0000, 4'b0000, 4'h8);

        for (int i = 0; i < 25; i++) begin
            step(tbl[i]);
            if (i == 1) chk("rsp_scale_reset", 32'(rsp_scale), 32'd0);
        end

        // Idle cycles after a grant of idx 2: LUT index is held.
        step(mk(1'b1, 4'b0100, pk(4'h0, 4'h2, 4'h0, 4'h0), 4'b0100, 4'h2));
        for (int i = 0; i < 3; i++) step(mk(1'b1, 4'b0000, 16'h0000, 4'b0000, 4'h2));

        // Reset the cycle after a grant: no response, pointer back to lane 0.
        step(mk(1'b1, 4'b0010, pk(4'h0, 4'h0, 4'h1, 4'h0), 4'b0010, 4'h1));
        step(mk(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'h0));
        step(mk(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'h0));
        step(mk(1'b1, 4'b0000, 16'h0000, 4'b0000, 4'h0));
        chk("rsp_scale_after_reset", 32'(rsp_scale), 32'd0);
        step(mk(1'b1, 4'b0000, 16'h0000, 4'b0000, 4'h0));
        step(mk(1'b1, 4'b1010, pk(4'h5, 4'h0, 4'h3, 4'h0), 4'b0010, 4'h3));
        for (int i = 0; i < 3; i++) step(mk(1'b1, 4'b0000, 16'h0000, 4'b0000, 4'h3));

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exp_scale_arb.md
Name: exp_scale_arb

Overview:
- Round-robin arbiter that shares one registered exponent-scale LUT among NUM_REQ exp-computation lanes in the 16b_frac PE.
- Accepts per-lane lookup requests (valid/ready), drives the LUT index, tracks in-flight lookups through the LUT latency, and returns each scale word to the lane that asked for it.
- Fully pipelined: at most one grant per cycle, no bubbles under continuous load.

Parameters:
- NUM_REQ, 4: number of requesting lanes; 2 to 8.
- IDX_W, 4: LUT index width (exp_int).
- SCALE_W, 20: LUT output width (exp_scale).
- LUT_LAT, 1: LUT read latency in cycles; 1 to 3.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-lane lookup request
- req_idx  in  NUM_REQ*IDX_W  per-lane index; lane i occupies bits [i*IDX_W +: IDX_W]
- req_ready  out  NUM_REQ  one-hot grant; handshake completes when req_valid[i] & req_ready[i]
- lut_idx  out  IDX_W  index driven to the shared LUT
- lut_scale  in  SCALE_W  LUT result, valid LUT_LAT cycles after lut_idx is presented
- rsp_valid  out  NUM_REQ  one-hot, registered; lane i's result is on rsp_scale
- rsp_scale  out  SCALE_W  registered scale word
- inflight  out  2  number of granted lookups not yet returned (0 to LUT_LAT+1, saturates display at 3)

Behaviour:
- Reset (async assert, sync release):
  - rr_ptr=0, tag pipeline cleared, lut_idx hold register=0.
  - rsp_valid=0, rsp_scale=0, inflight=0.
  - req_ready is combinational from req_valid and rr_ptr, so it is 0 whenever req_valid is 0.
- Arbitration, combinational each cycle:
  - Grant the first lane i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready[i]=1 only for that lane; all zero if no lane is requesting.
  - On a grant to lane g, rr_ptr <= (g+1) mod NUM_REQ at the clock edge. rr_ptr is unchanged on idle cycles.
- Requester rules: req_idx must stay stable while req_valid is high and not yet granted. Dropping req_valid before the grant is legal and is not an error.
- LUT drive:
  - Grant cycle: lut_idx = req_idx of the granted lane, combinational.
  - Idle cycle: lut_idx holds the last granted index from a register, to avoid toggling the LUT.
- Tag pipeline, LUT_LAT stages of {valid, lane id}:
  - Stage 0 loads {grant, g} each cycle.
  - When the last stage is valid, rsp_scale <= lut_scale and rsp_valid <= onehot(lane id) on the next edge.
  - Otherwise rsp_valid <= 0 and rsp_scale holds its value.
- Latency:
  - Handshake in cycle t gives rsp_valid in cycle t+LUT_LAT+1.
  - Responses return in grant order.
  - Responses have no backpressure; lanes must accept rsp_valid unconditionally.
- Throughput: 1 grant per cycle. Back-to-back grants to the same lane are legal when it is the only requester.
- inflight: +1 on grant, −1 when rsp_valid is asserted, both in the same cycle gives net 0. Registered.
- Reset mid-operation: all tags are dropped. LUT data arriving after reset release is ignored because the tags are cleared. No rsp_valid is produced for pre-reset grants.
- Out-of-range lane ids cannot occur. An assertion checks that rsp_valid is at most one-hot.

Test Plan:
- Reset, then lane 0 requests idx 4'h1 in cycle 3 -> req_ready=4'b0001 in cycle 3, lut_idx=4'h1, rsp_valid=4'b0001 with rsp_scale=20'h02B80 in cycle 5 (LUT_LAT=1).
- Lanes 0–3 all request continuously with idx 0, 1, 2, 8 -> grants 0,1,2,3,0,… one per cycle; rsp_scale sequence 20'h01000, 20'h02B80, 20'h07640, 20'h00160 on lanes 0,1,2,3; inflight holds at 2.
- rr_ptr=2, lanes 0 and 3 request -> lane 3 is granted first, then lane 0; rr_ptr ends at 1.
- Lane 1 alone for 4 cycles with idx 0 -> 4 back-to-back grants to lane 1 and 4 consecutive rsp_valid=4'b0010 cycles with value 20'h01000.
- Idle cycles after a grant of idx 4'h2 -> lut_idx stays 4'h2, req_ready=0, rsp_valid=0.
- Assert rst_n=0 the cycle after a grant -> rsp_valid stays 0 during and after reset; inflight=0; the next grant goes to the lowest requesting lane, since rr_ptr=0.
